// File: rtl/byte_serializer.sv
// Parallel-to-serial stage: accepts a WIDTH-bit word over valid/ready and shifts it
// out one bit per downstream handshake, optionally idling GAP cycles after each word.
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int              BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [BC_W-1:0]  w_bit_cnt_nxt;
  logic [3:0]       r_gap_cnt;
  logic [3:0]       w_gap_cnt_nxt;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] w_word_cnt_nxt;
  logic             w_in_ready;
  logic             w_ser_valid;
  logic             w_tap;
  logic             w_last;

  // The tap is always the bit about to leave; the register shifts toward it.
  assign w_tap  = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign w_last = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_in_ready     = 1'b0;
    w_ser_valid    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_shreg_nxt   = in_data;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_ser_valid = 1'b1;
        if (ser_ready) begin
          w_shreg_nxt = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]}
                                  : {r_shreg[WIDTH-2:0], 1'b0};
          if (w_last) begin
            w_bit_cnt_nxt  = '0;
            w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
            w_gap_cnt_nxt  = GAP_LOAD;
            w_state_nxt    = (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign ser_valid = w_ser_valid;
  assign ser_out   = w_ser_valid & w_tap;
  assign ser_last  = w_last;
  assign busy      = (r_state != S_IDLE);
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_byte_serializer.sv
// Two serializer instances (LSB-first/no gap/2-bit counter and MSB-first/gap 3/16-bit
// counter) driven by directed and random words, checked by a bit-queue scoreboard.
module tb_byte_serializer;

  localparam int W    = 8;
  localparam int CW0  = 2;
  localparam int CW1  = 16;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;
  localparam bit LSB0 = 1'b1;
  localparam bit LSB1 = 1'b0;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data [2];
  logic [1:0]     in_valid = '0;
  logic [1:0]     ser_ready = '0;
  logic [1:0]     in_ready, ser_out, ser_valid, ser_last, busy;
  logic [CW0-1:0] wc0;
  logic [CW1-1:0] wc1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   exp_words[2];
  int   last_hs[2];
  int   acc_cyc[2];
  bit   stalled[2];
  logic held_b[2];
  logic held_l[2];
  bit   gap_run[2];
  int   gap_n[2];
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_serializer #(.WIDTH(W), .LSB_FIRST(LSB0), .GAP(GAP0), .CNT_W(CW0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .ser_last(ser_last[0]), .busy(busy[0]), .word_cnt(wc0)
  );

  byte_serializer #(.WIDTH(W), .LSB_FIRST(LSB1), .GAP(GAP1), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .ser_last(ser_last[1]), .busy(busy[1]), .word_cnt(wc1)
  );

  function automatic bit lsb_of(input int k);
    return (k == 0) ? LSB0 : LSB1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? GAP0 : GAP1;
  endfunction

  function automatic int cw_of(input int k);
    return (k == 0) ? CW0 : CW1;
  endfunction

  function automatic logic [31:0] get_wc(input int k);
    return (k == 0) ? 32'(wc0) : 32'(wc1);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", name, k, cyc, act, exp);
    end
  endtask

  // Reference: word i-th transmitted bit is d[i] (LSB first) or d[W-1-i] (MSB first).
  task automatic push_word(input int k, input logic [W-1:0] d);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b = lsb_of(k) ? d[i] : d[W-1-i];
      e.l = (i == W - 1);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    int   qs;
    check("word_cnt", k, get_wc(k), 32'(exp_words[k] % (1 << cw_of(k))));
    if (gap_run[k]) begin
      if (busy[k] && !ser_valid[k]) gap_n[k]++;
      else begin
        check("gap_len", k, gap_n[k], gap_of(k));
        gap_run[k] = 1'b0;
      end
    end
    if (stalled[k]) begin
      check("stall_valid", k, ser_valid[k], 1);
      check("stall_out", k, ser_out[k], held_b[k]);
      check("stall_last", k, ser_last[k], held_l[k]);
      stalled[k] = 1'b0;
    end
    if (!ser_valid[k]) begin
      check("idle_out_last", k, {ser_out[k], ser_last[k]}, 0);
    end else begin
      check("shift_ready_busy", k, {in_ready[k], busy[k]}, 1);
      if (ser_ready[k]) begin
        qs = (k == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          check("unexpected_bit", k, 1, 0);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check("ser_out", k, ser_out[k], e.b);
          check("ser_last", k, ser_last[k], e.l);
          if (e.l) begin
            exp_words[k]++;
            last_hs[k] = cyc;
            gap_run[k] = 1'b1;
            gap_n[k]   = 0;
          end
        end
      end else begin
        stalled[k] = 1'b1;
        held_b[k]  = ser_out[k];
        held_l[k]  = ser_last[k];
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        exp_words[k] = 0;
        stalled[k]   = 1'b0;
        gap_run[k]   = 1'b0;
      end
    end else begin
      mon(0);
      mon(1);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      ser_ready[0] = ($urandom_range(0, 3) != 0);
      ser_ready[1] = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input int k, input logic [W-1:0] d, input bit hold);
    int t = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready[k]) break;
      t++;
      if (t > 200) begin
        check("accept_timeout", k, 1, 0);
        in_valid[k] = 1'b0;
        return;
      end
    end
    acc_cyc[k] = cyc;
    @(posedge clk);
    #1;
    push_word(k, d);
    if (!hold) in_valid[k] = 1'b0;
    in_data[k] = W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy != 2'b00) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("drain_timeout", 0, 1, 0);
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; reset is applied on the following edge.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", k, in_ready[k], 1);
      check("rst_ser_valid", k, ser_valid[k], 0);
      check("rst_ser_out_last", k, {ser_out[k], ser_last[k]}, 0);
      check("rst_busy", k, busy[k], 0);
      check("rst_word_cnt", k, get_wc(k), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, p1;
    in_data[0] = '0;
    in_data[1] = '0;
    #1;
    do_reset();

    // Bit order on both instances, ready held high.
    ser_ready = 2'b11;
    fork
      send(0, 8'b1001_0000, 1'b0);
      send(1, 8'b1001_0000, 1'b0);
    join
    drain();
    check("first_word_cnt", 0, get_wc(0), 1);
    fork
      send(0, 8'hA5, 1'b0);
      send(1, 8'hA5, 1'b0);
    join
    drain();

    // Backpressure: 2 bits, 3 stalled cycles, then the rest.
    fork
      send(0, 8'hC3, 1'b0);
      send(1, 8'hC3, 1'b0);
    join
    @(posedge clk);
    @(posedge clk);
    #1 ser_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1 ser_ready = 2'b11;
    drain();
    for (int k = 0; k < 2; k++) check("word_time", k, last_hs[k] - acc_cyc[k], 11);

    // Back-to-back with in_valid held: accept spacing is WIDTH+1+GAP.
    fork
      begin
        send(0, 8'h01, 1'b1);
        p0 = acc_cyc[0];
        send(0, 8'h80, 1'b1);
        in_valid[0] = 1'b0;
        check("accept_interval", 0, acc_cyc[0] - p0, 9);
      end
      begin
        send(1, 8'h01, 1'b1);
        p1 = acc_cyc[1];
        send(1, 8'h80, 1'b1);
        in_valid[1] = 1'b0;
        check("accept_interval", 1, acc_cyc[1] - p1, 12);
      end
    join
    drain();

    // Reset after 4 bits of 8'hFF, then a clean word.
    fork
      send(0, 8'hFF, 1'b0);
      send(1, 8'hFF, 1'b0);
    join
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    fork
      send(0, 8'h0F, 1'b0);
      send(1, 8'h0F, 1'b0);
    join
    drain();
    check("post_reset_cnt", 0, get_wc(0), 1);
    check("post_reset_cnt", 1, get_wc(1), 1);

    // Random words, random idle spacing and random downstream stalls.
    rand_ready = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        send(0, W'($urandom), 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 25; i++) begin
        send(1, W'($urandom), 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    join
    rand_ready = 1'b0;
    @(posedge clk);
    #2 ser_ready = 2'b11;
    drain();
    check("final_cnt", 0, get_wc(0), 32'(26 % 4));
    check("final_cnt", 1, get_wc(1), 26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
